// File: rtl/warp_fetch_scheduler.sv
// Per-warp fetch scheduler: round-robin selection of up to two distinct warps per cycle
// for the two IF lanes, tracking per-warp fetch state and I-buffer credits.
module warp_fetch_scheduler #(
    parameter int unsigned IB_DEPTH = 2,
    parameter int unsigned CW       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Warp_Start,
    input  logic [7:0] Dec_Valid0,
    input  logic [7:0] Dec_Valid1,
    input  logic       Dec_Ctrl0,
    input  logic       Dec_Ctrl1,
    input  logic       Dec_Exit0,
    input  logic       Dec_Exit1,
    input  logic [7:0] Br_Resolve,
    input  logic [7:0] IB_Pop,
    output logic [7:0] Grant_IF0,
    output logic [7:0] Grant_IF1,
    output logic [7:0] Warp_Idle,
    output logic [7:0] Credit_Empty
);

    localparam int unsigned NW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_INFLIGHT,
        ST_BRWAIT
    } wstate_e;

    wstate_e           state_q [NW];
    wstate_e           state_d [NW];
    logic [CW-1:0]     credit_q [NW];
    logic [CW-1:0]     credit_d [NW];
    logic [2:0]        ptr_q, ptr_d;
    logic [NW-1:0]     grant0_q, grant0_d;
    logic [NW-1:0]     grant1_q, grant1_d;
    logic [NW-1:0]     idle_q, idle_d;
    logic [NW-1:0]     cempty_q, cempty_d;

    logic [NW-1:0]     elig;
    logic [2:0]        scan_idx;
    logic [2:0]        idx0, idx1;
    logic              found0, found1;

    // Two-deep round-robin scan starting at ptr, using start-of-cycle state only
    always_comb begin
        elig     = '0;
        scan_idx = '0;
        idx0     = '0;
        idx1     = '0;
        found0   = 1'b0;
        found1   = 1'b0;
        grant0_d = '0;
        grant1_d = '0;
        ptr_d    = ptr_q;
        for (int i = 0; i < int'(NW); i++) begin
            elig[i] = (state_q[i] == ST_READY) && (credit_q[i] != '0);
        end
        for (int k = 0; k < int'(NW); k++) begin
            scan_idx = ptr_q + 3'(k);
            if (elig[scan_idx]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    idx0   = scan_idx;
                end else if (!found1) begin
                    found1 = 1'b1;
                    idx1   = scan_idx;
                end
            end
        end
        if (found0) begin
            grant0_d[idx0] = 1'b1;
            ptr_d          = idx0 + 3'd1;
        end
        if (found1) begin
            grant1_d[idx1] = 1'b1;
            ptr_d          = idx1 + 3'd1;
        end
    end

    // Per-warp state and credit next-state; lane 0 wins when both lanes return the same warp
    always_comb begin
        idle_d   = '0;
        cempty_d = '0;
        for (int i = 0; i < int'(NW); i++) begin
            logic granted;
            logic ret_ctrl;
            logic ret_exit;
            state_d[i]  = state_q[i];
            credit_d[i] = credit_q[i];
            granted     = grant0_d[i] | grant1_d[i];
            ret_ctrl    = Dec_Valid0[i] ? Dec_Ctrl0 : Dec_Ctrl1;
            ret_exit    = Dec_Valid0[i] ? Dec_Exit0 : Dec_Exit1;
            case (state_q[i])
                ST_IDLE:     if (Warp_Start[i]) state_d[i] = ST_READY;
                ST_READY:    if (granted) state_d[i] = ST_INFLIGHT;
                ST_INFLIGHT: begin
                    if (Dec_Valid0[i] || Dec_Valid1[i]) begin
                        if (ret_exit) begin
                            state_d[i] = ST_IDLE;
                        end else if (ret_ctrl) begin
                            state_d[i] = ST_BRWAIT;
                        end else begin
                            state_d[i] = ST_READY;
                        end
                    end
                end
                ST_BRWAIT:   if (Br_Resolve[i]) state_d[i] = ST_READY;
                default:     state_d[i] = ST_IDLE;
            endcase
            if (granted && !IB_Pop[i]) begin
                credit_d[i] = credit_q[i] - CW'(1);
            end else if (!granted && IB_Pop[i] && (credit_q[i] < CW'(IB_DEPTH))) begin
                credit_d[i] = credit_q[i] + CW'(1);
            end
            idle_d[i]   = (state_d[i] == ST_IDLE);
            cempty_d[i] = (credit_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NW); i++) begin
                state_q[i]  <= ST_IDLE;
                credit_q[i] <= CW'(IB_DEPTH);
            end
            ptr_q    <= '0;
            grant0_q <= '0;
            grant1_q <= '0;
            idle_q   <= '1;
            cempty_q <= '0;
        end else begin
            for (int i = 0; i < int'(NW); i++) begin
                state_q[i]  <= state_d[i];
                credit_q[i] <= credit_d[i];
            end
            ptr_q    <= ptr_d;
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            idle_q   <= idle_d;
            cempty_q <= cempty_d;
        end
    end

    assign Grant_IF0    = grant0_q;
    assign Grant_IF1    = grant1_q;
    assign Warp_Idle    = idle_q;
    assign Credit_Empty = cempty_q;

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Bench for warp_fetch_scheduler: directed vector table, round-robin sequence and
// randomized traffic checked against a queue-based reference model.
module tb_warp_fetch_scheduler;

    localparam int IB = 2;
    localparam int M_IDLE = 0, M_READY = 1, M_INFL = 2, M_BR = 3;

    typedef struct {
        logic [7:0] start, dv0, dv1;
        logic       c0, c1, e0, e1;
        logic [7:0] br, pop;
        logic [7:0] g0, g1, idle, ce;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] Warp_Start, Dec_Valid0, Dec_Valid1, Br_Resolve, IB_Pop;
    logic       Dec_Ctrl0, Dec_Ctrl1, Dec_Exit0, Dec_Exit1;
    logic [7:0] Grant_IF0, Grant_IF1, Warp_Idle, Credit_Empty;

    int total = 0;
    int bad   = 0;

    int         m_st [8];
    int         m_cr [8];
    int         m_ptr;
    logic [7:0] m_g0, m_g1, m_idle, m_ce;

    warp_fetch_scheduler #(.IB_DEPTH(2), .CW(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Warp_Start   (Warp_Start),
        .Dec_Valid0   (Dec_Valid0),
        .Dec_Valid1   (Dec_Valid1),
        .Dec_Ctrl0    (Dec_Ctrl0),
        .Dec_Ctrl1    (Dec_Ctrl1),
        .Dec_Exit0    (Dec_Exit0),
        .Dec_Exit1    (Dec_Exit1),
        .Br_Resolve   (Br_Resolve),
        .IB_Pop       (IB_Pop),
        .Grant_IF0    (Grant_IF0),
        .Grant_IF1    (Grant_IF1),
        .Warp_Idle    (Warp_Idle),
        .Credit_Empty (Credit_Empty)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] st, input logic [7:0] d0, input logic [7:0] d1,
                                input logic c0, input logic c1, input logic e0, input logic e1,
                                input logic [7:0] br, input logic [7:0] pop,
                                input logic [7:0] g0, input logic [7:0] g1,
                                input logic [7:0] idle, input logic [7:0] ce);
        vec_t v;
        v.start = st; v.dv0 = d0; v.dv1 = d1;
        v.c0 = c0; v.c1 = c1; v.e0 = e0; v.e1 = e1;
        v.br = br; v.pop = pop;
        v.g0 = g0; v.g1 = g1; v.idle = idle; v.ce = ce;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 8; w++) begin
            m_st[w] = M_IDLE;
            m_cr[w] = IB;
        end
        m_ptr = 0; m_g0 = '0; m_g1 = '0; m_idle = 8'hFF; m_ce = '0;
    endtask

    // Reference: list eligible warps in scan order, hand out the first two, then apply rules
    task automatic model_step(input vec_t v);
        int         el[$];
        logic [7:0] g0, g1;
        logic       gr;
        g0 = '0; g1 = '0;
        for (int k = 0; k < 8; k++) begin
            int w;
            w = (m_ptr + k) % 8;
            if (m_st[w] == M_READY && m_cr[w] > 0) el.push_back(w);
        end
        if (el.size() > 0) g0[el[0]] = 1'b1;
        if (el.size() > 1) g1[el[1]] = 1'b1;
        if (el.size() > 1) m_ptr = (el[1] + 1) % 8;
        else if (el.size() == 1) m_ptr = (el[0] + 1) % 8;
        for (int w = 0; w < 8; w++) begin
            gr = g0[w] | g1[w];
            case (m_st[w])
                M_IDLE:  if (v.start[w]) m_st[w] = M_READY;
                M_READY: if (gr) m_st[w] = M_INFL;
                M_INFL: begin
                    if (v.dv0[w]) m_st[w] = v.e0 ? M_IDLE : (v.c0 ? M_BR : M_READY);
                    else if (v.dv1[w]) m_st[w] = v.e1 ? M_IDLE : (v.c1 ? M_BR : M_READY);
                end
                default: if (v.br[w]) m_st[w] = M_READY;
            endcase
            if (gr && !v.pop[w]) m_cr[w]--;
            else if (!gr && v.pop[w] && m_cr[w] < IB) m_cr[w]++;
        end
        m_g0 = g0; m_g1 = g1;
        for (int w = 0; w < 8; w++) begin
            m_idle[w] = (m_st[w] == M_IDLE);
            m_ce[w]   = (m_cr[w] == 0);
        end
    endtask

    task automatic drive(input vec_t v);
        Warp_Start = v.start; Dec_Valid0 = v.dv0; Dec_Valid1 = v.dv1;
        Dec_Ctrl0 = v.c0; Dec_Ctrl1 = v.c1; Dec_Exit0 = v.e0; Dec_Exit1 = v.e1;
        Br_Resolve = v.br; IB_Pop = v.pop;
    endtask

    // One clock: drive away from the edge, advance model, sample #1 after the edge
    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v);
        model_step(v);
        @(posedge clk);
        #1;
        check("model_g0", Grant_IF0, m_g0);
        check("model_g1", Grant_IF1, m_g1);
        check("model_idle", Warp_Idle, m_idle);
        check("model_cempty", Credit_Empty, m_ce);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_g0", Grant_IF0, 8'h00);
        check("rst_g1", Grant_IF1, 8'h00);
        check("rst_idle", Warp_Idle, 8'hFF);
        check("rst_cempty", Credit_Empty, 8'h00);
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl [21];
    vec_t zv;

    initial begin
        zv = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
        tbl[0]  = mk(8'h01, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00);
        tbl[1]  = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h01, 8'h00, 8'hFE, 8'h00);
        tbl[2]  = mk(8'h00, 8'h01, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00);
        tbl[3]  = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h01, 8'h00, 8'hFE, 8'h01);
        tbl[4]  = mk(8'h00, 8'h00, 8'h01, 0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h01);
        tbl[5]  = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h01);
        tbl[6]  = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFE, 8'h00);
        tbl[7]  = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h01, 8'h00, 8'hFE, 8'h01);
        tbl[8]  = mk(8'h00, 8'h01, 8'h00, 1,0,0,0, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFE, 8'h00);
        tbl[9]  = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00);
        tbl[10] = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h01, 8'h01, 8'h00, 8'hFE, 8'h00);
        tbl[11] = mk(8'h00, 8'h00, 8'h01, 0,1,0,1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);
        tbl[12] = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);
        tbl[13] = mk(8'h40, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBF, 8'h00);
        tbl[14] = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h40, 8'h00, 8'hBF, 8'h00);
        tbl[15] = mk(8'h81, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3E, 8'h00);
        tbl[16] = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h80, 8'h01, 8'h3E, 8'h01);
        tbl[17] = mk(8'h00, 8'h80, 8'h40, 0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3E, 8'h01);
        tbl[18] = mk(8'hC0, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h40, 8'h80, 8'h3E, 8'hC1);
        tbl[19] = mk(8'h00, 8'h01, 8'h01, 0,1,0,0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h3E, 8'hC0);
        tbl[20] = mk(8'h00, 8'h00, 8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h3E, 8'hC1);

        rst_n = 1'b0;
        drive(zv);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_g0", Grant_IF0, 8'h00);
        check("init_g1", Grant_IF1, 8'h00);
        check("init_idle", Warp_Idle, 8'hFF);
        check("init_cempty", Credit_Empty, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, returns biased toward warps the model has in flight
        for (int n = 0; n < 1500; n++) begin
            vec_t v;
            int   infl[$];
            v = zv;
            for (int w = 0; w < 8; w++) if (m_st[w] == M_INFL) infl.push_back(w);
            if ($urandom_range(3) == 0) v.start = 8'($urandom);
            if (infl.size() > 0 && $urandom_range(1) == 1) v.dv0[infl[$urandom_range(infl.size()-1)]] = 1'b1;
            if (infl.size() > 0 && $urandom_range(1) == 1) v.dv1[infl[$urandom_range(infl.size()-1)]] = 1'b1;
            else if ($urandom_range(7) == 0) v.dv1[$urandom_range(7)] = 1'b1;
            v.c0 = ($urandom_range(3) == 0);
            v.c1 = ($urandom_range(3) == 0);
            v.e0 = ($urandom_range(7) == 0);
            v.e1 = ($urandom_range(7) == 0);
            if ($urandom_range(2) == 0) v.br = 8'($urandom);
            v.pop = 8'($urandom) & 8'($urandom);
            step(v);
            if (n == 700) do_reset();
        end

        // Directed vector table starting from a mid-run reset
        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(tbl[i]);
            check($sformatf("vec%0d_g0", i), Grant_IF0, tbl[i].g0);
            check($sformatf("vec%0d_g1", i), Grant_IF1, tbl[i].g1);
            check($sformatf("vec%0d_idle", i), Warp_Idle, tbl[i].idle);
            check($sformatf("vec%0d_cempty", i), Credit_Empty, tbl[i].ce);
        end

        // Round-robin pairs with all warps launched and every grant returned and popped
        do_reset();
        begin
            vec_t       v;
            logic [7:0] pg0, pg1, e0, e1;
            v = zv;
            v.start = 8'hFF;
            step(v);
            pg0 = Grant_IF0;
            pg1 = Grant_IF1;
            for (int r = 0; r < 5; r++) begin
                v = zv;
                v.dv0 = pg0;
                v.dv1 = pg1;
                v.pop = pg0 | pg1;
                step(v);
                e0 = 8'(1) << (2 * (r % 4));
                e1 = 8'(1) << (2 * (r % 4) + 1);
                check($sformatf("rr%0d_g0", r), Grant_IF0, e0);
                check($sformatf("rr%0d_g1", r), Grant_IF1, e1);
                pg0 = e0;
                pg1 = e1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
